detector_jogada_botoes: RTL and testbench

- Upstream input stage of the memory game (jogo_desafio_memoria); converts the raw `botoes[3:0]` into clean play events.
- Synchronizes the raw buttons, debounces them, rejects multi-button presses, and produces a one-cycle `tem_jogada` pulse with the held one-hot play code.
- Optionally times out when no play occurs within a window, feeding the game's defeat-by-timeout path.

---
 rtl/genius_pkg.sv | 23 ++
 rtl/debounce_botoes.sv | 53 +++++
 rtl/detector_jogada_botoes.sv | 135 +++++++++++++
 tb/tb_detector_jogada_botoes.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/genius_pkg.sv
// Shared types for the memory-game input stage: FSM state encoding, one-hot button codes,
// and a one-hot test helper.
package genius_pkg;

  typedef enum logic [2:0] {
    OCIOSO         = 3'd0,
    ESPERA_SOLTO   = 3'd1,
    ESPERA_APERTO  = 3'd2,
    ACEITA         = 3'd3,
    ESPERA_SOLTURA = 3'd4
  } estado_t;

  localparam logic [3:0] BOTAO_0 = 4'b0001;
  localparam logic [3:0] BOTAO_1 = 4'b0010;
  localparam logic [3:0] BOTAO_2 = 4'b0100;
  localparam logic [3:0] BOTAO_3 = 4'b1000;

  // Exactly one bit set: non-zero and clearing the lowest set bit leaves nothing.
  function automatic logic eh_one_hot(input logic [3:0] v);
    return (v != 4'b0000) && ((v & (v - 4'd1)) == 4'b0000);
  endfunction

endpackage

// File: rtl/debounce_botoes.sv
// Two-flop synchronizer plus debounce; raw change to estavel is DEBOUNCE_CICLOS+1 edges.
// No backpressure: estavel tracks the buttons continuously.
module debounce_botoes #(
  parameter int unsigned DEBOUNCE_CICLOS = 20
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] botoes,
  output logic [3:0] estavel
);

  localparam int unsigned CW = (DEBOUNCE_CICLOS > 2) ? $clog2(DEBOUNCE_CICLOS) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CICLOS - 1);

  logic [3:0]    meta_q;
  logic [3:0]    sinc_q;
  logic [3:0]    estavel_q;
  logic [3:0]    estavel_d;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // The clear fires on the edge where sinc takes its new value, so the counter
  // counts the cycles sinc has already held that value.
  always_comb begin
    cnt_d     = cnt_q;
    estavel_d = estavel_q;
    if (meta_q != sinc_q) begin
      cnt_d = '0;
    end else if (cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + 1'b1;
    end
    if (cnt_d == CNT_MAX) begin
      estavel_d = sinc_q;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      meta_q    <= '0;
      sinc_q    <= '0;
      cnt_q     <= '0;
      estavel_q <= '0;
    end else begin
      meta_q    <= botoes;
      sinc_q    <= meta_q;
      cnt_q     <= cnt_d;
      estavel_q <= estavel_d;
    end
  end

  assign estavel = estavel_q;

endmodule

// File: rtl/detector_jogada_botoes.sv
// Raw buttons -> one-hot play pulses; raw edge to tem_jogada is DEBOUNCE_CICLOS+2 cycles, no backpressure.
// DETECTOR_JOGADA_TIMEOUT_EN adds the no-press timeout out of ESPERA_APERTO.
module detector_jogada_botoes
  import genius_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CICLOS = 20,
  parameter int unsigned TIMEOUT_CICLOS  = 3000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       habilita,
  input  logic [3:0] botoes,
  output logic       tem_jogada,
  output logic [3:0] jogada,
  output logic       jogada_invalida,
  output logic       timeout,
  output logic [3:0] db_estado
);

  logic [3:0] estavel;

  debounce_botoes #(
    .DEBOUNCE_CICLOS(DEBOUNCE_CICLOS)
  ) u_debounce (
    .clock  (clock),
    .reset  (reset),
    .botoes (botoes),
    .estavel(estavel)
  );

  estado_t    estado_q;
  estado_t    estado_d;
  logic       tem_q;
  logic       tem_d;
  logic       inv_q;
  logic       inv_d;
  logic       to_q;
  logic       to_d;
  logic [3:0] jog_q;
  logic [3:0] jog_d;
  logic       to_fim;

`ifdef DETECTOR_JOGADA_TIMEOUT_EN
  localparam int unsigned TW = (TIMEOUT_CICLOS > 2) ? $clog2(TIMEOUT_CICLOS) : 1;
  localparam logic [TW-1:0] TO_MAX = TW'(TIMEOUT_CICLOS - 1);

  logic [TW-1:0] to_cnt_q;
  logic [TW-1:0] to_cnt_d;

  // Idle at zero outside ESPERA_APERTO, so every entry starts a fresh window.
  always_comb begin
    to_cnt_d = '0;
    if (estado_q == ESPERA_APERTO) begin
      to_cnt_d = to_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      to_cnt_q <= '0;
    end else begin
      to_cnt_q <= to_cnt_d;
    end
  end

  assign to_fim = (to_cnt_q == TO_MAX);
`else
  assign to_fim = 1'b0;
`endif

  // Priority: disarm, then a press (valid before invalid), then the timeout.
  always_comb begin
    estado_d = estado_q;
    tem_d    = 1'b0;
    inv_d    = 1'b0;
    to_d     = 1'b0;
    jog_d    = jog_q;
    if (!habilita) begin
      estado_d = OCIOSO;
    end else begin
      case (estado_q)
        OCIOSO: begin
          estado_d = ESPERA_SOLTO;
        end
        ESPERA_SOLTO, ESPERA_SOLTURA: begin
          if (estavel == 4'b0000) begin
            estado_d = ESPERA_APERTO;
          end
        end
        ESPERA_APERTO: begin
          if (eh_one_hot(estavel)) begin
            estado_d = ACEITA;
            tem_d    = 1'b1;
            jog_d    = estavel;
          end else if (estavel != 4'b0000) begin
            estado_d = ESPERA_SOLTO;
            inv_d    = 1'b1;
          end else if (to_fim) begin
            estado_d = OCIOSO;
            to_d     = 1'b1;
          end
        end
        ACEITA: begin
          estado_d = ESPERA_SOLTURA;
        end
        default: begin
          estado_d = OCIOSO;
        end
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado_q <= OCIOSO;
      tem_q    <= 1'b0;
      inv_q    <= 1'b0;
      to_q     <= 1'b0;
      jog_q    <= 4'b0000;
    end else begin
      estado_q <= estado_d;
      tem_q    <= tem_d;
      inv_q    <= inv_d;
      to_q     <= to_d;
      jog_q    <= jog_d;
    end
  end

  assign tem_jogada      = tem_q;
  assign jogada          = jog_q;
  assign jogada_invalida = inv_q;
  assign timeout         = to_q;
  assign db_estado       = {1'b0, estado_q};

endmodule

// File: tb/tb_detector_jogada_botoes.sv
// Bench for detector_jogada_botoes: directed table, multi-cycle corner sequences, random vs reference model.
module tb_detector_jogada_botoes;
  import genius_pkg::*;

  localparam int unsigned DEB = 20;
  localparam int unsigned TO  = 50;
`ifdef DETECTOR_JOGADA_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic       clock    = 1'b0;
  logic       reset    = 1'b0;
  logic       habilita = 1'b0;
  logic [3:0] botoes   = 4'b0000;
  logic       tem_jogada;
  logic [3:0] jogada;
  logic       jogada_invalida;
  logic       timeout;
  logic [3:0] db_estado;

  detector_jogada_botoes #(
    .DEBOUNCE_CICLOS(DEB),
    .TIMEOUT_CICLOS (TO)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .habilita       (habilita),
    .botoes         (botoes),
    .tem_jogada     (tem_jogada),
    .jogada         (jogada),
    .jogada_invalida(jogada_invalida),
    .timeout        (timeout),
    .db_estado      (db_estado)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_pass   = 0;
  int c_tem    = 0;
  int c_inv    = 0;
  int c_to     = 0;
  logic [3:0] last_code = 4'b0000;
  bit modelo_on = 1'b0;

  task automatic check(input string nome, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", nome, act, exp);
  endtask

  // Reference model: debounce as "last DEB synchronized samples all equal",
  // play detection as the phase sequence idle/arm/await press/accept/await release.
  int unsigned ph;
  int unsigned m_cnt;
  logic [3:0]  m_est, m_jog;
  bit          m_tem, m_inv, m_to;
  logic [3:0]  rawq[$];

  task automatic model_reset();
    ph = 0; m_cnt = 0; m_est = 4'b0000; m_jog = 4'b0000;
    m_tem = 0; m_inv = 0; m_to = 0;
    rawq.delete();
    for (int i = 0; i <= DEB; i++) rawq.push_back(4'b0000);
  endtask

  task automatic model_step(input logic [3:0] raw, input logic hab);
    logic [3:0] e;
    bit igual;
    e = m_est;
    m_tem = 0; m_inv = 0; m_to = 0;
    if (!hab) ph = 0;
    else begin
      case (ph)
        0: ph = 1;
        1, 4: if (e == 4'b0000) begin ph = 2; m_cnt = 0; end
        2: begin
          if ($countones(e) == 1) begin ph = 3; m_tem = 1; m_jog = e; end
          else if ($countones(e) > 1) begin ph = 1; m_inv = 1; end
          else if (TO_EN && m_cnt == TO - 1) begin ph = 0; m_to = 1; end
          else m_cnt++;
        end
        default: ph = 4;
      endcase
    end
    rawq.push_back(raw);
    void'(rawq.pop_front());
    igual = 1;
    for (int i = 1; i < DEB; i++) if (rawq[i] != rawq[0]) igual = 0;
    if (igual) m_est = rawq[0];
  endtask

  task automatic tick();
    @(posedge clock);
    if (modelo_on) model_step(botoes, habilita);
    @(negedge clock);
    if (tem_jogada) begin c_tem++; last_code = jogada; end
    if (jogada_invalida) c_inv++;
    if (timeout) c_to++;
    if (modelo_on)
      check("rand_saidas", {25'd0, tem_jogada, jogada_invalida, timeout, jogada},
            {25'd0, m_tem, m_inv, m_to, m_jog});
  endtask

  task automatic arm();
    habilita = 1'b0; tick();
    habilita = 1'b1; tick(); tick();
  endtask

  task automatic zera();
    c_tem = 0; c_inv = 0; c_to = 0;
  endtask

  typedef struct {
    logic [3:0]  val;
    int unsigned hold;
    logic        hab;
    int          n_tem;
    int          n_inv;
    int          n_to;
    logic [3:0]  jog;
    logic [3:0]  db;
  } vec_t;

  vec_t tab[8];

  initial begin
    int lat, w, t_at;
    logic [3:0] code;

    tab[0] = '{4'b0001, 100, 1'b1, 1, 0, 0, 4'b0001, 4'd2};
    tab[1] = '{4'b0011, 100, 1'b1, 0, 1, 0, 4'b0001, 4'd2};
    tab[2] = '{4'b0100,  10, 1'b1, 0, 0, 0, 4'b0001, 4'd2};
    tab[3] = '{4'b1000,  20, 1'b1, 1, 0, 0, 4'b1000, 4'd2};
    tab[4] = '{4'b1000,  19, 1'b1, 0, 0, 0, 4'b1000, 4'd2};
    tab[5] = '{4'b1111,  50, 1'b1, 0, 1, 0, 4'b1000, 4'd2};
    tab[6] = '{4'b0010,  60, 1'b0, 0, 0, 0, 4'b1000, 4'd0};
    tab[7] = '{4'b0010,  60, 1'b1, 1, 0, 0, 4'b0010, 4'd2};

    // Reset state, then arming walks OCIOSO -> ESPERA_SOLTO -> ESPERA_APERTO.
    @(negedge clock);
    check("rst_saidas", {25'd0, tem_jogada, jogada_invalida, timeout, jogada}, 32'd0);
    check("rst_db", db_estado, 0);
    reset = 1'b1; habilita = 1'b1;
    tick();
    check("arm_db1", db_estado, 1);
    tick();
    check("arm_db2", db_estado, 2);
    check("arm_saidas", {25'd0, tem_jogada, jogada_invalida, timeout, jogada}, 32'd0);

    for (int i = 0; i < 8; i++) begin
      arm();
      habilita = tab[i].hab;
      botoes   = tab[i].val;
      zera();
      repeat (tab[i].hold) tick();
      botoes = 4'b0000;
      repeat (30) tick();
      check($sformatf("tab%0d_tem", i), c_tem, tab[i].n_tem);
      check($sformatf("tab%0d_inv", i), c_inv, tab[i].n_inv);
      check($sformatf("tab%0d_to", i), c_to, tab[i].n_to);
      check($sformatf("tab%0d_jog", i), jogada, tab[i].jog);
      check($sformatf("tab%0d_db", i), db_estado, tab[i].db);
    end

    // Bouncing press: arm on the final raw change, pulse 22 edges later.
    habilita = 1'b0; zera();
    for (int b = 0; b < 3; b++) begin
      botoes = BOTAO_2; repeat (5) tick();
      botoes = 4'b0000; repeat (5) tick();
    end
    botoes = BOTAO_2; habilita = 1'b1; lat = 0;
    for (int k = 1; k <= 100; k++) begin
      tick();
      if (tem_jogada && lat == 0) lat = k;
    end
    botoes = 4'b0000; repeat (30) tick();
    check("bounce_lat", lat, 22);
    check("bounce_tem", c_tem, 1);
    check("bounce_jog", jogada, BOTAO_2);

    // Button held across arming is ignored; the next clean press is taken.
    habilita = 1'b0; botoes = BOTAO_1; zera();
    repeat (200) tick();
    habilita = 1'b1; repeat (50) tick();
    botoes = 4'b0000; repeat (30) tick();
    check("held_tem", c_tem, 0);
    check("held_inv", c_inv, 0);
    check("held_jog", jogada, BOTAO_2);
    botoes = BOTAO_3; repeat (60) tick();
    botoes = 4'b0000; repeat (30) tick();
    check("after_held_tem", c_tem, 1);
    check("after_held_jog", jogada, BOTAO_3);

    // Timeout window measured from the edge that enters ESPERA_APERTO.
    habilita = 1'b0; tick(); habilita = 1'b1; zera();
    w = 0;
    while (db_estado != 4'd2 && w < 10) begin tick(); w++; end
    check("to_arm", db_estado, 2);
    t_at = 0;
    for (int k = 1; k <= 500; k++) begin
      tick();
      if (timeout) begin t_at = k; break; end
    end
    check("to_ciclos", t_at, TO_EN ? TO : 0);
    check("to_db", db_estado, TO_EN ? 0 : 2);
    check("to_tem", c_tem, 0);

    // Asynchronous reset two cycles after a pulse rises.
    arm(); botoes = BOTAO_0; w = 0;
    while (!tem_jogada && w < 60) begin tick(); w++; end
    check("mid_pulse", tem_jogada, 1);
    tick(); tick();
    #2 reset = 1'b0;
    #1;
    check("mid_rst_jog", jogada, 0);
    check("mid_rst_db", db_estado, 0);
    check("mid_rst_tem", tem_jogada, 0);
    botoes = 4'b0000;
    @(negedge clock);
    reset = 1'b1;
    arm(); zera();
    for (int i = 0; i < 16; i++) begin
      code = 4'b0001 << (i % 4);
      botoes = code; repeat (25) tick();
      botoes = 4'b0000; repeat (25) tick();
      check($sformatf("seq%0d_code", i), last_code, code);
    end
    check("seq_tem", c_tem, 16);
    check("seq_inv", c_inv, 0);

    // Random segments against the reference model, from a fresh reset.
    habilita = 1'b0; botoes = 4'b0000;
    reset = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    model_reset();
    modelo_on = 1'b1;
    for (int s = 0; s < 100; s++) begin
      int unsigned r;
      r = $urandom_range(0, 9);
      if (r < 4) botoes = 4'b0000;
      else if (r < 8) botoes = 4'b0001 << $urandom_range(0, 3);
      else botoes = 4'($urandom_range(0, 15));
      habilita = ($urandom_range(0, 9) != 0);
      repeat ($urandom_range(1, 45)) tick();
    end
    modelo_on = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
